tri_state_bus_receiver: RTL
===========================

// Module: tri_state_bus_receiver
// PURPOSE
//  Receiving end of the shared 8-bit tri-state data bus. Samples the bus while the remote
//  driver's enable is high, skips a settle window after each enable rise (bus turnaround),
//  buffers captured words in a small FIFO and presents them on a valid/ready interface.
//  Asserts a hold request back to the driver before the buffer fills.
// PARAMETERS
//  DATA_W       8   bus / word width
//  DEPTH        4   FIFO entries, power of 2, >=2
//  SETTLE_CYC   1   cycles ignored after enable rise (0..15; 0 = capture immediately)
//  HOLD_THRESH  3   fill level (DEPTH-1 default) at which bus_hold_out asserts
// PORTS
//  clk_in          in   1        single clock, all logic on rising edge
//  rst_n_in        in   1        synchronous reset, active-low
//  bus_data_in     in   DATA_W   resolved value of the tri-state bus
//  bus_en_in       in   1        remote driver enable (1 = bus driven)
//  bus_hold_out    out  1        back-pressure request to driver
//  rx_data_out     out  DATA_W   head-of-FIFO word
//  rx_valid_out    out  1        rx_data_out valid (FIFO non-empty)
//  rx_ready_in     in   1        consumer accepts word when valid&ready
//  overflow_out    out  1        sticky: a captured word was dropped
//  fifo_count_out  out  clog2(DEPTH)+1  current fill level
// BEHAVIOUR
//  - Reset (rst_n_in=0 at edge): all outputs 0, FIFO emptied, ptrs 0, FSM IDLE, input regs 0.
//    Reset mid-burst discards FIFO contents and in-flight sample; no partial state survives.
//  - Input stage: bus_data_in, bus_en_in registered once (data_r, en_r) every cycle.
//  - FSM on en_r: IDLE -> (en_r=1) SETTLE, loading cnt=SETTLE_CYC; if SETTLE_CYC=0 go CAPTURE
//    and push data_r in that same cycle.
//    SETTLE: cnt decrements; en_r=0 -> IDLE; cnt==1 & en_r=1 -> CAPTURE (no push this cycle).
//    CAPTURE: push data_r every cycle en_r=1; en_r=0 -> IDLE, no push.
//  - Latency (SETTLE_CYC=0): bus value at edge N -> rx_data_out/rx_valid_out after edge N+2.
//    Each settle cycle adds one cycle before the first word of a burst only.
//  - FIFO: no fall-through; rx_valid_out = (count!=0); pop on rx_valid_out & rx_ready_in.
//    ready while empty: ignored. Push+pop same cycle: count unchanged, both performed,
//    including when full (pop frees the slot, push accepted, no overflow).
//    Push while full without pop: word dropped, overflow_out set; cleared only by reset.
//    Pointers wrap modulo DEPTH; count saturates at DEPTH, never exceeds.
//  - bus_hold_out registered: 1 the cycle after count >= HOLD_THRESH, 0 the cycle after
//    count < HOLD_THRESH. Receiver keeps capturing while hold is high; driver must honour it.
//  - rx_data_out stable while rx_valid_out=1 and rx_ready_in=0.
//  - X/Z on bus_data_in outside enable windows is never captured.
// STRUCTURE
//  - Package tri_bus_pkg: DATA_W default, rx_state_t enum {IDLE, SETTLE, CAPTURE},
//    count-width helper constant.
//  - One sub-module: rx_sync_fifo (DATA_W, DEPTH; push/pop/full/empty/count, registered array).
//  - Top holds input regs, settle counter, FSM, hold and overflow flags.
// TESTING
//  1 Reset: hold rst_n_in=0 3 cycles with bus_en_in=1, data=0xAA -> all outputs 0, count 0.
//  2 SETTLE_CYC=1, en high 4 cycles, data 0x01..0x04 (one per cycle), ready=1 -> receive
//    0x02,0x03,0x04 in order (first word inside settle dropped), no overflow.
//  3 ready=0, burst of 6 words 0x10..0x15 (DEPTH=4) -> count 4, first 4 held, overflow_out=1,
//    bus_hold_out=1 one cycle after count reaches 3; after drain receive 0x10..0x13.
//  4 FIFO full, push and pop same cycle -> count stays 4, overflow_out stays 0, order kept.
//  5 en toggles every cycle (1-cycle pulses, SETTLE_CYC=1) -> no words captured, FSM back to IDLE.
//  6 Reset asserted mid-burst with count=2 -> next cycle count 0, rx_valid_out 0, overflow 0;
//    new burst after release captured normally.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri-state bus receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tri_bus_pkg;

  localparam int TRI_DATA_W = 8;
  localparam int TRI_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } rx_state_t;

  // Fill-level width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Synchronous FIFO with registered storage and no fall-through.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push while full without pop is refused; push+pop when full both happen.
module rx_sync_fifo
  import tri_bus_pkg::*;
#(
  parameter int DATA_W = TRI_DATA_W,
  parameter int DEPTH  = TRI_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_push_dat,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_head_dat,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);
  // A pop on a full FIFO frees the slot the concurrent push will use.
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage, pointers and fill level; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Head is forced to zero when empty so stale words never appear on the output.
  assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;

endmodule

// File: rtl/tri_state_bus_receiver.sv
// Receiver for the shared tri-state bus: samples while enabled, skips turnaround, buffers words.
// Latency: bus value changing at edge N is on rx_data_out after edge N+2 (plus one per settle cycle, first word only).
// Backpressure: bus_hold_out rises one cycle after fill >= HOLD_THRESH; words arriving when full are dropped (sticky overflow).
module tri_state_bus_receiver
  import tri_bus_pkg::*;
#(
  parameter int DATA_W      = TRI_DATA_W,
  parameter int DEPTH       = TRI_DEPTH,
  parameter int SETTLE_CYC  = 1,
  parameter int HOLD_THRESH = DEPTH - 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [DATA_W-1:0]       bus_data_in,
  input  logic                    bus_en_in,
  output logic                    bus_hold_out,
  output logic [DATA_W-1:0]       rx_data_out,
  output logic                    rx_valid_out,
  input  logic                    rx_ready_in,
  output logic                    overflow_out,
  output logic [$clog2(DEPTH):0]  fifo_count_out
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] HOLD_LVL = CW'(HOLD_THRESH);
  // The IDLE cycle that detects the enable rise is itself the first ignored cycle,
  // so the SETTLE state only has to cover the remaining SETTLE_CYC-1 cycles.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYC > 1) ? 4'(SETTLE_CYC - 1) : 4'd0;

  logic [DATA_W-1:0] r_data;
  logic              r_en;
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_hold;
  logic              r_ovf;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [DATA_W-1:0] w_head;

  // Register the bus and its enable once before any decision is made.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_data <= '0;
      r_en   <= 1'b0;
    end else begin
      r_data <= bus_data_in;
      r_en   <= bus_en_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Settle counter: loaded on the enable rise, counts down through SETTLE.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)                      r_cnt <= '0;
    else if (r_state == IDLE && r_en)   r_cnt <= SETTLE_LOAD;
    else if (r_state == SETTLE)         r_cnt <= r_cnt - 1'b1;
  end

  // Next-state logic driven by the registered enable.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_en) w_state_nxt = (SETTLE_CYC <= 1) ? CAPTURE : SETTLE;
      SETTLE: begin
        if (!r_en)              w_state_nxt = IDLE;
        else if (r_cnt == 4'd1) w_state_nxt = CAPTURE;
      end
      CAPTURE: if (!r_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: which cycles push the registered bus word.
  always_comb begin
    w_push = 1'b0;
    case (r_state)
      IDLE:    w_push = r_en && (SETTLE_CYC == 0);
      CAPTURE: w_push = r_en;
      default: w_push = 1'b0;
    endcase
  end

  assign w_pop = ~w_empty & rx_ready_in;

  rx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk      (clk_in),
    .i_rst_n    (rst_n_in),
    .i_push     (w_push),
    .i_push_dat (r_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // Hold request follows the fill level with one register of delay; overflow is sticky.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_hold <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_hold <= (w_count >= HOLD_LVL);
      r_ovf  <= r_ovf | (w_push & w_full & ~w_pop);
    end
  end

  assign bus_hold_out   = r_hold;
  assign overflow_out   = r_ovf;
  assign rx_data_out    = w_head;
  assign rx_valid_out   = ~w_empty;
  assign fifo_count_out = w_count;

endmodule
